// File: rtl/fifodcx_ctl_pkg.sv
// Shared types and constants for the FIFO dibit write scheduler.
// One byte goes out as four dibits, least-significant dibit first.
package fifodcx_ctl_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam int BEATS   = 4;
    localparam int DIBIT_W = 2;
    localparam int BYTE_W  = BEATS * DIBIT_W;

    function automatic logic [DIBIT_W-1:0] lsb_dibit(input logic [BYTE_W-1:0] b);
        return b[DIBIT_W-1:0];
    endfunction

endpackage

// File: rtl/fifodcx_rr_arb2.sv
// Two-way round-robin arbiter. The priority flag moves only when a grant is taken,
// so a requester that is refused keeps its turn.
module fifodcx_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prio_b_q;
    logic prio_b_d;

    // Grant decode and next-priority computation
    always_comb begin
        grant    = 2'b00;
        prio_b_d = prio_b_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_b_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        if (advance && (grant != 2'b00)) begin
            prio_b_d = grant[0];
        end else begin
            prio_b_d = prio_b_q;
        end
    end

    // Priority register; reset favours requester A
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/fifodcx_wr_sched.sv
// Arbitrates two byte requesters onto a 2-bit FIFO write port, holding the FIFO
// in reset for a fixed interval after Reset and stalling beats while the FIFO is full.
module fifodcx_wr_sched
    import fifodcx_ctl_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             WrClock,
    input  logic             Reset,
    input  logic             ReqA_Valid,
    input  logic [7:0]       ReqA_Data,
    output logic             ReqA_Ready,
    input  logic             ReqB_Valid,
    input  logic [7:0]       ReqB_Data,
    output logic             ReqB_Ready,
    input  logic             FifoFull,
    input  logic             FifoAlmostFull,
    output logic             FifoData0,
    output logic             FifoData1,
    output logic             FifoWrEn,
    output logic             FifoReset,
    output logic             Busy,
    output logic             LastGrantB,
    output logic [CNT_W-1:0] ByteCount
);

    localparam logic [3:0]         RST_LAST  = 4'(RST_CYCLES);
    localparam logic [1:0]         LAST_BEAT = 2'(BEATS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_e            state_q;
    logic [3:0]        init_cnt_q;
    logic [BYTE_W-1:0] shift_q;
    logic [1:0]        beat_q;
    logic              last_b_q;
    logic [CNT_W-1:0]  byte_cnt_q;

    logic [1:0]        arb_req_s;
    logic [1:0]        grant_s;
    logic              accept_s;
    logic              wr_en_s;
    logic [BYTE_W-1:0] acc_data_s;
    logic [DIBIT_W-1:0] dibit_s;

    // Ready is offered only in IDLE and only when the FIFO has headroom for a whole byte
    always_comb begin
        if ((state_q == ST_IDLE) && !FifoAlmostFull) begin
            arb_req_s = {ReqB_Valid, ReqA_Valid};
        end else begin
            arb_req_s = 2'b00;
        end
        accept_s   = |grant_s;
        acc_data_s = grant_s[1] ? ReqB_Data : ReqA_Data;
        wr_en_s    = (state_q == ST_SEND) && !FifoFull;
        dibit_s    = lsb_dibit(shift_q);
    end

    fifodcx_rr_arb2 u_arb (
        .clk     (WrClock),
        .reset   (Reset),
        .req     (arb_req_s),
        .advance (accept_s),
        .grant   (grant_s)
    );

    assign ReqA_Ready = grant_s[0];
    assign ReqB_Ready = grant_s[1];
    assign FifoWrEn   = wr_en_s;
    assign FifoData0  = wr_en_s & dibit_s[0];
    assign FifoData1  = wr_en_s & dibit_s[1];
    assign FifoReset  = (state_q == ST_INIT);
    assign Busy       = (state_q != ST_IDLE);
    assign LastGrantB = last_b_q;
    assign ByteCount  = byte_cnt_q;

    // Scheduler FSM: FIFO reset interval, byte acceptance, dibit serialisation
    always_ff @(posedge WrClock) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 4'd0;
            shift_q    <= '0;
            beat_q     <= 2'd0;
            last_b_q   <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // The reset edge itself counts as the first FifoReset cycle
                    if (init_cnt_q == RST_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        init_cnt_q <= init_cnt_q + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_q  <= acc_data_s;
                        last_b_q <= grant_s[1];
                        beat_q   <= 2'd0;
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (wr_en_s) begin
                        shift_q <= {{DIBIT_W{1'b0}}, shift_q[BYTE_W-1:DIBIT_W]};
                        beat_q  <= beat_q + 2'd1;
                        if (beat_q == LAST_BEAT) begin
                            state_q    <= ST_IDLE;
                            byte_cnt_q <= byte_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifodcx_wr_sched.sv
// Directed bench for fifodcx_wr_sched: reset interval, arbitration, dibit order,
// full-stall, almost-full gating and reset abort.
module tb_fifodcx_wr_sched;

    logic        WrClock = 1'b0;
    logic        Reset;
    logic        ReqA_Valid, ReqB_Valid;
    logic [7:0]  ReqA_Data, ReqB_Data;
    logic        ReqA_Ready, ReqB_Ready;
    logic        FifoFull, FifoAlmostFull;
    logic        FifoData0, FifoData1, FifoWrEn, FifoReset, Busy, LastGrantB;
    logic [15:0] ByteCount;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 WrClock = ~WrClock;

    fifodcx_wr_sched #(.RST_CYCLES(4), .CNT_W(16)) dut (
        .WrClock        (WrClock),
        .Reset          (Reset),
        .ReqA_Valid     (ReqA_Valid),
        .ReqA_Data      (ReqA_Data),
        .ReqA_Ready     (ReqA_Ready),
        .ReqB_Valid     (ReqB_Valid),
        .ReqB_Data      (ReqB_Data),
        .ReqB_Ready     (ReqB_Ready),
        .FifoFull       (FifoFull),
        .FifoAlmostFull (FifoAlmostFull),
        .FifoData0      (FifoData0),
        .FifoData1      (FifoData1),
        .FifoWrEn       (FifoWrEn),
        .FifoReset      (FifoReset),
        .Busy           (Busy),
        .LastGrantB     (LastGrantB),
        .ByteCount      (ByteCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge WrClock);
        #2;
    endtask

    initial begin
        int          cycles;
        logic        flag;
        int          ng;
        int          nwr;
        logic [7:0]  gseq;
        logic [31:0] recv;
        logic [1:0]  b4_exp [4];
        logic [1:0]  c6_exp [4];

        b4_exp = '{2'b00, 2'b01, 2'b11, 2'b10};
        c6_exp = '{2'b00, 2'b11, 2'b10, 2'b01};

        Reset = 1'b1;
        ReqA_Valid = 1'b1; ReqB_Valid = 1'b1;
        ReqA_Data = 8'h00; ReqB_Data = 8'h00;
        FifoFull = 1'b0; FifoAlmostFull = 1'b0;

        // One reset cycle, requesters already valid
        step;
        chk("rst_state", 32'({FifoReset, FifoWrEn, ReqB_Ready, ReqA_Ready, Busy}), 32'b10001);
        chk("rst_bytecount", 32'(ByteCount), 32'd0);
        Reset = 1'b0;
        cycles = 0;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!FifoReset) break;
            cycles++;
            if (ReqA_Ready || ReqB_Ready || FifoWrEn) flag = 1'b1;
            step;
        end
        chk("init_len", 32'(cycles), 32'd5);
        chk("init_quiet", 32'(flag), 32'd0);
        chk("idle_busy", 32'(Busy), 32'd0);

        // Both valid continuously: alternation and 20-cycle throughput
        ReqA_Data = 8'h11; ReqB_Data = 8'h22;
        #1;
        ng = 0; nwr = 0; gseq = 8'h00; recv = 32'h0; flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ReqA_Ready && ReqB_Ready) flag = 1'b1;
            if ((ReqA_Ready || ReqB_Ready) && ng < 8) begin
                gseq[ng] = ReqB_Ready;
                ng++;
            end
            if (FifoWrEn) begin
                recv = {FifoData1, FifoData0, recv[31:2]};
                nwr++;
            end
            step;
        end
        chk("rr_both_ready", 32'(flag), 32'd0);
        chk("rr_grants", 32'(ng), 32'd4);
        chk("rr_order", 32'(gseq), 32'h0a);
        chk("rr_writes", 32'(nwr), 32'd16);
        chk("rr_data", recv, 32'h22112211);
        chk("rr_bytecount", 32'(ByteCount), 32'd4);
        chk("rr_lastb", 32'({Busy, LastGrantB}), 32'b01);
        ReqA_Valid = 1'b0; ReqB_Valid = 1'b0;

        // A alone sends 0xB4
        ReqA_Valid = 1'b1; ReqA_Data = 8'hB4;
        #1;
        chk("b4_ready", 32'({ReqB_Ready, ReqA_Ready}), 32'b01);
        step;
        ReqA_Valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b4_beat", 32'({FifoWrEn, FifoData1, FifoData0}), 32'({1'b1, b4_exp[k]}));
            step;
        end
        chk("b4_done", 32'({FifoWrEn, Busy, LastGrantB}), 32'b000);
        chk("b4_bytecount", 32'(ByteCount), 32'd5);

        // FifoFull for three cycles at beat 2 of 0x6C
        ReqA_Valid = 1'b1; ReqA_Data = 8'h6C;
        step;
        ReqA_Valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("stall_pre", 32'({FifoWrEn, FifoData1, FifoData0}), 32'({1'b1, c6_exp[k]}));
            step;
        end
        FifoFull = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_hold", 32'({Busy, FifoWrEn, FifoData1, FifoData0}), 32'b1000);
            step;
        end
        FifoFull = 1'b0;
        #1;
        for (int k = 2; k < 4; k++) begin
            chk("stall_post", 32'({FifoWrEn, FifoData1, FifoData0}), 32'({1'b1, c6_exp[k]}));
            step;
        end
        chk("stall_bytecount", 32'({Busy, ByteCount}), 32'd6);

        // AlmostFull gates Ready in IDLE
        FifoAlmostFull = 1'b1;
        ReqA_Valid = 1'b1; ReqA_Data = 8'h5A;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("af_gated", 32'({Busy, ReqB_Ready, ReqA_Ready}), 32'b000);
            step;
        end
        FifoAlmostFull = 1'b0;
        #1;
        chk("af_release", 32'({ReqB_Ready, ReqA_Ready}), 32'b01);
        step;
        ReqA_Valid = 1'b0;
        chk("abort_beat0", 32'({FifoWrEn, FifoData1, FifoData0}), 32'b110);

        // Reset right after the first beat aborts the byte
        Reset = 1'b1;
        step;
        chk("abort_state", 32'({FifoReset, FifoWrEn, ReqB_Ready, ReqA_Ready, Busy, LastGrantB}), 32'b100010);
        chk("abort_bytecount", 32'(ByteCount), 32'd0);
        step;
        Reset = 1'b0;
        cycles = 0;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!FifoReset) break;
            cycles++;
            if (FifoWrEn) flag = 1'b1;
            step;
        end
        chk("abort_init_len", 32'(cycles), 32'd5);
        chk("abort_no_wr", 32'({flag, FifoWrEn, Busy}), 32'b000);
        chk("abort_final_cnt", 32'(ByteCount), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifodcx_wr_sched.md
FIFODCX_WR_SCHED -- requirements
Module: fifodcx_wr_sched

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles FifoReset stays high after Reset deasserts (legal range 1..15).
REQ-002 Parameter CNT_W, default 16: width of ByteCount.
REQ-003 Port WrClock  in  1  single clock; all logic is rising-edge on WrClock.
REQ-004 Port Reset  in  1  synchronous, active-high reset.
REQ-005 Port ReqA_Valid  in  1  requester A offers a byte.
REQ-006 Port ReqA_Data  in  8  requester A byte.
REQ-007 Port ReqA_Ready  out  1  requester A byte accepted this cycle when ReqA_Valid is also high.
REQ-008 Port ReqB_Valid / ReqB_Data / ReqB_Ready: the same as REQ-005..007 for requester B.
REQ-009 Port FifoFull  in  1  FIFO write-side Full flag.
REQ-010 Port FifoAlmostFull  in  1  FIFO write-side AlmostFull flag; its threshold is configured at least 4 entries below full.
REQ-011 Port FifoData0, FifoData1  out  1 each  dibit to the FIFO write port.
REQ-012 Port FifoWrEn  out  1  FIFO write enable.
REQ-013 Port FifoReset  out  1  FIFO Reset/RPReset drive.
REQ-014 Port Busy  out  1  high in any state other than IDLE.
REQ-015 Port LastGrantB  out  1  requester of the most recent accepted byte (1 = B).
REQ-016 Port ByteCount  out  CNT_W  number of completed bytes, wrapping modulo 2^CNT_W.

Function
REQ-017 The FSM SHALL have exactly three states: INIT, IDLE and SEND.
REQ-018 INIT SHALL hold FifoReset=1 while a 4-bit counter counts RST_CYCLES cycles after Reset is low, then go to IDLE.
REQ-019 In INIT, ReqA_Ready, ReqB_Ready and FifoWrEn SHALL be 0.
REQ-020 In IDLE with FifoAlmostFull=0, the block SHALL drive Ready combinationally to exactly one valid requester.
REQ-021 Arbitration SHALL use a round-robin pointer: with both requesters valid, the one not granted last wins, and the pointer updates only on acceptance.
REQ-022 In IDLE with FifoAlmostFull=1, both Ready outputs SHALL be 0.
REQ-023 On acceptance (Valid & Ready), the byte SHALL be latched into a shift register, LastGrantB updated, the beat counter cleared and the state set to SEND on the next edge.
REQ-024 In SEND, FifoWrEn SHALL equal !FifoFull.
REQ-025 Each SEND cycle with FifoWrEn=1 SHALL emit one dibit, LSB-first: beat k carries FifoData0=bit 2k and FifoData1=bit 2k+1, k=0..3.
REQ-026 A SEND cycle with FifoFull=1 SHALL stall, holding the dibit and beat counter unchanged.
REQ-027 After the 4th written beat, the block SHALL return to IDLE and increment ByteCount by 1 (wrapping from all-ones to 0).
REQ-028 No Ready SHALL be asserted during SEND, giving a minimum of 5 cycles per byte.
REQ-029 With no stalls, an acceptance in cycle N SHALL produce FifoWrEn in cycles N+1..N+4.
REQ-030 FifoData0 and FifoData1 SHALL be 0 whenever FifoWrEn=0.

Reset
REQ-031 Reset high at an edge SHALL force the state to INIT, clear the INIT counter, and clear the beat counter, ByteCount, LastGrantB and the round-robin pointer (next grant favours A).
REQ-032 During and after reset, outputs SHALL be FifoReset=1, FifoWrEn=0, both Ready=0, Busy=1 and ByteCount=0.
REQ-033 Reset during SEND SHALL abort the partial byte with no further FifoWrEn; FIFO contents are discarded through FifoReset.
REQ-034 While Reset stays high, the INIT counter SHALL remain 0.

Structure
REQ-035 Package fifodcx_ctl_pkg SHALL hold the state enum, the BEATS=4 constant and the dibit width constant.
REQ-036 The 2-way round-robin arbiter SHALL be the sub-module fifodcx_rr_arb2, with inputs req[1:0], advance and clk/reset, and output grant[1:0] (one-hot or zero).
REQ-037 All outputs except the Ready signals SHALL be registered or decoded only from the state.

Verification
REQ-038 Reset 1 cycle, then idle: FifoReset high for exactly 1+4 cycles, then Busy=0.
REQ-039 A sends 0xB4 alone: FifoWrEn for 4 consecutive cycles with dibits (Data1,Data0) = 00, 01, 11, 10, after which ByteCount=1.
REQ-040 A and B both valid continuously, A=0x11, B=0x22: grants alternate A,B,A,B, and 4 bytes take 20 cycles.
REQ-041 FifoFull pulsed high for 3 cycles during beat 2: the dibit is held, FifoWrEn=0 for 3 cycles, and the byte completes 3 cycles late and intact.
REQ-042 FifoAlmostFull=1 in IDLE with A valid: ReqA_Ready stays 0 until it drops.
REQ-043 Reset asserted after beat 1 of a byte: no further FifoWrEn, FifoReset high, and ByteCount=0.
